// File: rtl/dice_display_scan.sv
// Two-digit multiplexed 7-segment scan controller: dead time, PWM brightness,
// leading-zero blanking and frame-aligned (tear-free) digit updates.
module dice_display_scan #(
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit1,
    input  logic [3:0] digit10,
    input  logic       update,
    input  logic       blank_lz,
    input  logic [2:0] brightness,
    input  logic       seg_pol,
    input  logic       com_pol,
    output logic [7:0] seg_out,
    output logic [1:0] com_out,
    output logic [1:0] com_oe,
    output logic       frame_start
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
    localparam int ON_UNIT = (SCAN_DIV - BLANK_CYCLES) >> 3;

    typedef enum logic {
        SLOT_UNITS = 1'b0,
        SLOT_TENS  = 1'b1
    } slot_e;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    slot_e            slot_q, slot_d;
    logic [3:0]       pend1_q, pend1_d, pend10_q, pend10_d;
    logic [3:0]       act1_q, act1_d, act10_q, act10_d;
    logic [2:0]       bright_q, bright_d;
    logic             slot_bound_s, frame_bound_s, visible_s, com_on_s;
    logic [3:0]       digit_s;
    logic [7:0]       lit_s, seg_d;
    logic [1:0]       com_d;
    int               on_len_s, cnt_int_s;

    function automatic logic [7:0] seg_decode(input logic [3:0] code);
        logic [7:0] pat;
        case (code)
            4'd0:    pat = 8'h3F;
            4'd1:    pat = 8'h06;
            4'd2:    pat = 8'h5B;
            4'd3:    pat = 8'h4F;
            4'd4:    pat = 8'h66;
            4'd5:    pat = 8'h6D;
            4'd6:    pat = 8'h7D;
            4'd7:    pat = 8'h07;
            4'd8:    pat = 8'h7F;
            4'd9:    pat = 8'h6F;
            default: pat = 8'h00;
        endcase
        return pat;
    endfunction

    // Next-state for scan position, digit registers and output patterns.
    always_comb begin
        slot_bound_s  = (cnt_q == {CNT_W{1'b0}});
        frame_bound_s = slot_bound_s && (slot_q == SLOT_UNITS);

        if (cnt_q == CNT_MAX) begin
            cnt_d  = {CNT_W{1'b0}};
            slot_d = (slot_q == SLOT_UNITS) ? SLOT_TENS : SLOT_UNITS;
        end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            slot_d = slot_q;
        end

        if (update) begin
            pend1_d  = digit1;
            pend10_d = digit10;
        end else begin
            pend1_d  = pend1_q;
            pend10_d = pend10_q;
        end

        // The boundary cycle already uses the newly latched values so a
        // zero-length dead time still shows a consistent frame.
        if (frame_bound_s) begin
            act1_d  = update ? digit1  : pend1_q;
            act10_d = update ? digit10 : pend10_q;
        end else begin
            act1_d  = act1_q;
            act10_d = act10_q;
        end

        bright_d  = slot_bound_s ? brightness : bright_q;
        on_len_s  = ON_UNIT * (int'(bright_d) + 1);
        cnt_int_s = int'(cnt_q);

        digit_s   = (slot_q == SLOT_TENS) ? act10_d : act1_d;
        visible_s = (digit_s < 4'd10) &&
                    !((slot_q == SLOT_TENS) && blank_lz && (digit_s == 4'd0));
        com_on_s  = visible_s && (cnt_int_s >= BLANK_CYCLES) &&
                    (cnt_int_s < BLANK_CYCLES + on_len_s);

        lit_s = com_on_s ? seg_decode(digit_s) : 8'h00;
        seg_d = seg_pol ? lit_s : ~lit_s;
        com_d[0] = (com_on_s && (slot_q == SLOT_UNITS)) ? com_pol : ~com_pol;
        com_d[1] = (com_on_s && (slot_q == SLOT_TENS))  ? com_pol : ~com_pol;
    end

    // State and registered outputs; reset forces the all-off display.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= {CNT_W{1'b0}};
            slot_q      <= SLOT_UNITS;
            pend1_q     <= 4'd15;
            pend10_q    <= 4'd15;
            act1_q      <= 4'd15;
            act10_q     <= 4'd15;
            bright_q    <= 3'd7;
            seg_out     <= seg_pol ? 8'h00 : 8'hFF;
            com_out     <= {2{~com_pol}};
            com_oe      <= 2'b00;
            frame_start <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            slot_q      <= slot_d;
            pend1_q     <= pend1_d;
            pend10_q    <= pend10_d;
            act1_q      <= act1_d;
            act10_q     <= act10_d;
            bright_q    <= bright_d;
            seg_out     <= seg_d;
            com_out     <= com_d;
            com_oe      <= 2'b11;
            frame_start <= frame_bound_s;
        end
    end

endmodule

// File: tb/tb_dice_display_scan.sv
// Randomized scoreboard bench for dice_display_scan against a frame-position
// reference model (SCAN_DIV=32, BLANK_CYCLES=8).
module tb_dice_display_scan;

    localparam int SD = 32;
    localparam int BL = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] digit1 = 4'd15, digit10 = 4'd15;
    logic       update = 1'b0, blank_lz = 1'b0;
    logic [2:0] brightness = 3'd7;
    logic       seg_pol = 1'b1, com_pol = 1'b0;
    logic [7:0] seg_out;
    logic [1:0] com_out, com_oe;
    logic       frame_start;

    dice_display_scan #(.SCAN_DIV(SD), .BLANK_CYCLES(BL)) dut (
        .clk(clk), .rst(rst), .digit1(digit1), .digit10(digit10),
        .update(update), .blank_lz(blank_lz), .brightness(brightness),
        .seg_pol(seg_pol), .com_pol(com_pol), .seg_out(seg_out),
        .com_out(com_out), .com_oe(com_oe), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] seg;
        logic [1:0] com;
        logic [1:0] oe;
        logic       fs;
        logic       cpol;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    logic [7:0] lut [16];
    int t_m = 0;
    int p1_m = 15, p10_m = 15, a1_m = 15, a10_m = 15, br_m = 7;

    initial begin
        lut[0] = 8'h3F; lut[1] = 8'h06; lut[2] = 8'h5B; lut[3] = 8'h4F;
        lut[4] = 8'h66; lut[5] = 8'h6D; lut[6] = 8'h7D; lut[7] = 8'h07;
        lut[8] = 8'h7F; lut[9] = 8'h6F;
        for (int i = 10; i < 16; i++) lut[i] = 8'h00;
    end

    // Reference model: frame position t in 0..2*SD-1 decides everything.
    initial begin
        forever begin
            exp_t e;
            int   pos, b, on_len, d;
            bit   tens, vis, on;
            @(posedge clk);
            e.cpol = com_pol;
            if (rst) begin
                e.seg = seg_pol ? 8'h00 : 8'hFF;
                e.com = {2{~com_pol}};
                e.oe  = 2'b00;
                e.fs  = 1'b0;
                t_m = 0; p1_m = 15; p10_m = 15; a1_m = 15; a10_m = 15; br_m = 7;
            end else begin
                tens = (t_m >= SD);
                pos  = t_m % SD;
                b    = (pos == 0) ? int'(brightness) : br_m;
                if (t_m == 0) begin
                    a1_m  = update ? int'(digit1)  : p1_m;
                    a10_m = update ? int'(digit10) : p10_m;
                end
                on_len = ((SD - BL) / 8) * (b + 1);
                d   = tens ? a10_m : a1_m;
                vis = (d < 10) && !(tens && blank_lz && d == 0);
                on  = vis && pos >= BL && pos < BL + on_len;
                e.seg = on ? lut[d] : 8'h00;
                if (!seg_pol) e.seg = ~e.seg;
                e.com[0] = (on && !tens) ? com_pol : ~com_pol;
                e.com[1] = (on && tens)  ? com_pol : ~com_pol;
                e.oe  = 2'b11;
                e.fs  = (t_m == 0);
                if (update) begin
                    p1_m  = int'(digit1);
                    p10_m = int'(digit10);
                end
                if (pos == 0) br_m = int'(brightness);
                t_m = (t_m + 1) % (2 * SD);
            end
            exp_q.push_back(e);
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: every registered output cycle is compared against the queue head.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("seg_out", seg_out, e.seg);
                check("com_out", {6'd0, com_out}, {6'd0, e.com});
                check("com_oe", {6'd0, com_oe}, {6'd0, e.oe});
                check("frame_start", {7'd0, frame_start}, {7'd0, e.fs});
                check("both_commons_active", {7'd0, (com_out === {2{e.cpol}})}, 8'd0);
            end
        end
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_pos(input int target);
        for (int i = 0; i < 2 * SD && t_m != target; i++) @(negedge clk);
    endtask

    task automatic pulse_update(input logic [3:0] u, input logic [3:0] t);
        digit1 = u; digit10 = t; update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    initial begin
        cycles(3);
        rst = 1'b0;
        cycles(10);
        pulse_update(4'd4, 4'd2);
        cycles(200);
        brightness = 3'd0;
        cycles(130);
        brightness = 3'd5;
        blank_lz = 1'b1;
        pulse_update(4'd1, 4'd0);
        cycles(130);
        blank_lz = 1'b0;
        cycles(130);
        wait_pos(10);
        pulse_update(4'd7, 4'd3);
        cycles(140);
        wait_pos(0);
        pulse_update(4'd5, 4'd9);
        cycles(70);
        seg_pol = 1'b0; com_pol = 1'b1;
        cycles(100);
        wait_pos(40);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            update = ($urandom_range(0, 15) == 0);
            digit1 = 4'($urandom_range(0, 15));
            digit10 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 40) == 0) brightness = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 60) == 0) blank_lz = ~blank_lz;
            if ($urandom_range(0, 150) == 0) seg_pol = ~seg_pol;
            if ($urandom_range(0, 150) == 0) com_pol = ~com_pol;
            rst = ($urandom_range(0, 400) == 0);
            @(negedge clk);
        end
        update = 1'b0;
        rst = 1'b0;
        cycles(3);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
